instr_mem_server: RTL and testbench
===================================

INSTR_MEM_SERVER -- requirements
Module: instr_mem_server

Interface
REQ-001 The block SHALL have parameter FILL_WORD, default 8'h00, the instruction returned for unloaded addresses and while not running.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port ReadAddress  input  8  fetch address driven by the CPU's PC.
REQ-005 The block SHALL have port instruction  output  8  instruction word for ReadAddress.
REQ-006 The block SHALL have port load_valid  input  1  load byte present.
REQ-007 The block SHALL have port load_data  input  8  program byte.
REQ-008 The block SHALL have port load_last  input  1  qualifies the final byte of the program.
REQ-009 The block SHALL have port load_ready  output  1  block accepts a load byte this cycle.
REQ-010 The block SHALL have port reload  input  1  request to return from RUN to LOAD.
REQ-011 The block SHALL have port running  output  1  high in RUN state.
REQ-012 The block SHALL have port prog_len  output  9  number of bytes loaded (0..256).
REQ-013 The block SHALL have port checksum  output  8  modulo-256 sum of loaded bytes.

Function
REQ-014 The FSM SHALL have exactly two states: LOAD and RUN.
REQ-015 In LOAD, load_ready SHALL be 1; in RUN, load_ready SHALL be 0.
REQ-016 A transfer SHALL occur on a rising edge with load_valid=1 and load_ready=1: mem[wptr] <= load_data, wptr and prog_len increment by 1.
REQ-017 A transfer with load_last=1 SHALL be stored and move the FSM to RUN on the same edge.
REQ-018 A transfer at wptr=255 SHALL be stored and move the FSM to RUN with prog_len=256, regardless of load_last.
REQ-019 load_last without load_valid SHALL be ignored.
REQ-020 In RUN, instruction SHALL be combinational, with zero latency: mem[ReadAddress] when ReadAddress < prog_len, else FILL_WORD.
REQ-021 In LOAD, instruction SHALL equal FILL_WORD regardless of ReadAddress.
REQ-022 In RUN, reload=1 on an edge SHALL move the FSM to LOAD and clear wptr, prog_len and checksum to 0; memory contents need not be cleared.
REQ-023 In LOAD, reload SHALL be ignored.
REQ-024 running SHALL be 1 exactly in RUN.
REQ-025 Arithmetic SHALL be as follows: wptr is 8-bit; prog_len is 9-bit with no wrap; checksum wraps modulo 256.

Reset
REQ-026 Asserting reset SHALL immediately, without waiting for clk, force: state=LOAD, wptr=0, prog_len=0, checksum=0, running=0, load_ready=1, instruction=FILL_WORD.
REQ-027 Reset asserted mid-load SHALL discard progress; the next accepted byte SHALL be written to address 0.
REQ-028 Memory array contents SHALL NOT be reset.

Configuration
REQ-029 With macro INSTR_MEM_CHECKSUM_EN defined, checksum SHALL accumulate the sum of every transferred byte, updated on the transfer edge.
REQ-030 Without INSTR_MEM_CHECKSUM_EN, checksum SHALL be constant 8'h00 and no accumulator SHALL be built.

Structure
REQ-031 A shared package SHALL hold the state enum (LOAD, RUN), the depth constant MEM_DEPTH=256, the address width constant 8 and the data width constant 8.
REQ-032 Storage SHALL be a sub-module instr_mem_array: 256x8, one synchronous write port and one asynchronous read port.
REQ-033 The FSM, counters and output mux SHALL reside in instr_mem_server.

Verification
REQ-034 Load bytes 8'h41, 8'h82, 8'hC3 with load_last on the third byte -> running=1 on the next cycle, prog_len=3, instruction at addresses 0/1/2 = 41/82/C3, instruction at address 3 = 00, checksum=86 (with macro).
REQ-035 Hold load_valid=1 for 256 bytes of value i, with load_last=0 throughout -> RUN after the 256th byte, prog_len=256, mem[255]=FF, checksum=80 (with macro).
REQ-036 Assert reset after 2 of 4 bytes, then load 8'h11 with load_last=1 -> mem[0]=11, prog_len=1.
REQ-037 In RUN with prog_len=3, pulse reload -> running=0, load_ready=1, prog_len=0, instruction=00 for all addresses; a following load of 8'h55 with load_last=1 -> mem[0]=55.
REQ-038 Pulse load_valid with no data transfer expected while in RUN, and pulse load_last alone in LOAD -> no memory change and no state change.
REQ-039 Build without INSTR_MEM_CHECKSUM_EN and run the REQ-034 load -> checksum=00, all other results unchanged.

Source files
------------

// File: rtl/instr_mem_server_pkg.sv
// ============================================================================
//  Module      : instr_mem_server_pkg
//  Description : Shared types and sizing constants for the instruction memory
//                server.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_mem_server_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_mem_array.sv
// ============================================================================
//  Module      : instr_mem_array
//  Description : 256x8 program store, one synchronous write port and one
//                asynchronous read port. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_array
  import instr_mem_server_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_mem_server.sv
// ============================================================================
//  Module      : instr_mem_server
//  Description : Loads a program byte stream into instruction memory, then
//                serves zero-latency instruction fetches. Define
//                INSTR_MEM_CHECKSUM_EN to build the running byte checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic [DATA_WIDTH-1:0] instruction,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic                  reload,
  output logic                  running,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic [DATA_WIDTH-1:0] checksum
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH:0]   r_prog_len;
  logic                  w_xfer;
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_xfer = load_valid && (r_state == LOAD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= LOAD;
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_xfer) begin
            r_wptr     <= r_wptr + 1'b1;
            r_prog_len <= r_prog_len + 1'b1;
            // The last slot ends the load even without load_last.
            if (load_last || (r_wptr == ADDR_WIDTH'(MEM_DEPTH - 1))) begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (reload) begin
            r_state    <= LOAD;
            r_wptr     <= '0;
            r_prog_len <= '0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

`ifdef INSTR_MEM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_xfer) begin
      r_checksum <= r_checksum + load_data;
    end else if ((r_state == RUN) && reload) begin
      r_checksum <= '0;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  instr_mem_array u_mem (
    .clk   (clk),
    .we    (w_xfer),
    .waddr (r_wptr),
    .wdata (load_data),
    .raddr (ReadAddress),
    .rdata (w_mem_rdata)
  );

  // Nine-bit compare so that address 255 is valid when prog_len is 256.
  assign w_in_range  = ({1'b0, ReadAddress} < r_prog_len);
  assign instruction = ((r_state == RUN) && w_in_range) ? w_mem_rdata : FILL_WORD;

  assign running    = (r_state == RUN);
  assign load_ready = (r_state == LOAD);
  assign prog_len   = r_prog_len;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_server.sv
// ============================================================================
//  Module      : tb_instr_mem_server
//  Description : Directed self-checking bench for instr_mem_server; expected
//                checksums follow INSTR_MEM_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_server;

  localparam logic [7:0] FILL = 8'h00;

  logic       clk;
  logic       reset;
  logic [7:0] ReadAddress;
  logic [7:0] instruction;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       reload;
  logic       running;
  logic [8:0] prog_len;
  logic [7:0] checksum;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_server #(.FILL_WORD(FILL)) dut (
    .clk         (clk),
    .reset       (reset),
    .ReadAddress (ReadAddress),
    .instruction (instruction),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .running     (running),
    .prog_len    (prog_len),
    .checksum    (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Calls start and end #1 after a rising edge.
  task automatic push(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic check_instr(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    ReadAddress = addr;
    #1;
    check_val(tag, {24'h0, instruction}, {24'h0, exp});
  endtask

  function automatic logic [7:0] exp_sum(input logic [7:0] s);
`ifdef INSTR_MEM_CHECKSUM_EN
    return s;
`else
    return 8'h00 & s;
`endif
  endfunction

  initial begin
    reset       = 1'b1;
    ReadAddress = 8'h00;
    load_valid  = 1'b0;
    load_data   = 8'h00;
    load_last   = 1'b0;
    reload      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_val("rst_running", {31'h0, running}, 32'd0);
    check_val("rst_ready", {31'h0, load_ready}, 32'd1);
    check_val("rst_len", {23'h0, prog_len}, 32'd0);
    check_val("rst_sum", {24'h0, checksum}, 32'd0);
    check_instr("rst_instr", 8'h00, FILL);

    // Three-byte program
    push(8'h41, 1'b0);
    push(8'h82, 1'b0);
    check_instr("load_instr_fill", 8'h00, FILL);
    check_val("load_running", {31'h0, running}, 32'd0);
    push(8'hC3, 1'b1);
    check_val("p3_running", {31'h0, running}, 32'd1);
    check_val("p3_ready", {31'h0, load_ready}, 32'd0);
    check_val("p3_len", {23'h0, prog_len}, 32'd3);
    check_instr("p3_i0", 8'h00, 8'h41);
    check_instr("p3_i1", 8'h01, 8'h82);
    check_instr("p3_i2", 8'h02, 8'hC3);
    check_instr("p3_i3", 8'h03, FILL);
    check_val("p3_sum", {24'h0, checksum}, {24'h0, exp_sum(8'h86)});

    // load_valid in RUN has no effect
    push(8'hEE, 1'b1);
    check_val("run_valid_len", {23'h0, prog_len}, 32'd3);
    check_val("run_valid_state", {31'h0, running}, 32'd1);
    check_instr("run_valid_i0", 8'h00, 8'h41);
    check_val("run_valid_sum", {24'h0, checksum}, {24'h0, exp_sum(8'h86)});

    // Reload returns to LOAD
    pulse_reload();
    check_val("rl_running", {31'h0, running}, 32'd0);
    check_val("rl_ready", {31'h0, load_ready}, 32'd1);
    check_val("rl_len", {23'h0, prog_len}, 32'd0);
    check_val("rl_sum", {24'h0, checksum}, 32'd0);
    check_instr("rl_i0", 8'h00, FILL);
    check_instr("rl_i2", 8'h02, FILL);

    // Reload in LOAD and load_last alone are ignored
    pulse_reload();
    load_last = 1'b1;
    @(posedge clk);
    #1;
    load_last = 1'b0;
    check_val("ign_running", {31'h0, running}, 32'd0);
    check_val("ign_len", {23'h0, prog_len}, 32'd0);

    push(8'h55, 1'b1);
    check_val("p55_running", {31'h0, running}, 32'd1);
    check_val("p55_len", {23'h0, prog_len}, 32'd1);
    check_instr("p55_i0", 8'h00, 8'h55);
    check_instr("p55_i1_oob", 8'h01, FILL);
    check_val("p55_sum", {24'h0, checksum}, {24'h0, exp_sum(8'h55)});

    // Asynchronous reset mid-load discards progress
    pulse_reload();
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    check_val("mid_len", {23'h0, prog_len}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_len", {23'h0, prog_len}, 32'd0);
    check_val("async_sum", {24'h0, checksum}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(8'h11, 1'b1);
    check_val("p11_len", {23'h0, prog_len}, 32'd1);
    check_instr("p11_i0", 8'h00, 8'h11);
    check_instr("p11_i1_oob", 8'h01, FILL);
    check_val("p11_sum", {24'h0, checksum}, {24'h0, exp_sum(8'h11)});

    // Full 256-byte load without load_last
    pulse_reload();
    for (int i = 0; i < 256; i++) begin
      push(8'(i), 1'b0);
      if (i == 254) begin
        check_val("full_pre_running", {31'h0, running}, 32'd0);
      end
    end
    check_val("full_running", {31'h0, running}, 32'd1);
    check_val("full_len", {23'h0, prog_len}, 32'd256);
    check_instr("full_i255", 8'hFF, 8'hFF);
    check_instr("full_i0", 8'h00, 8'h00);
    check_instr("full_i128", 8'h80, 8'h80);
    check_val("full_sum", {24'h0, checksum}, {24'h0, exp_sum(8'h80)});

    // Asynchronous reset from RUN
    ReadAddress = 8'h05;
    #2;
    reset = 1'b1;
    #1;
    check_val("arun_running", {31'h0, running}, 32'd0);
    check_val("arun_ready", {31'h0, load_ready}, 32'd1);
    check_val("arun_instr", {24'h0, instruction}, {24'h0, FILL});
    check_val("arun_len", {23'h0, prog_len}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
